// File: rtl/gamepad_reader_pkg.sv
`default_nettype none
// gamepad_reader_pkg: poll FSM encoding and button bit indices shared by the game logic.
// Rev 1.0
package gamepad_reader_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LATCH    = 3'd1,
      PULSE_HI = 3'd2,
      PULSE_LO = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam int NUM_BTN    = 8;
   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   // Raw all-zero means the line is only pulled down: no pad, report nothing.
   function automatic logic [NUM_BTN-1:0] decode_buttons(input logic [NUM_BTN-1:0] raw);
      logic [NUM_BTN-1:0] pressed;
      pressed = ~raw;
      if (raw == '0) begin
         pressed = '0;
      end
      if (pressed[BTN_UP] && pressed[BTN_DOWN]) begin
         pressed[BTN_UP]   = 1'b0;
         pressed[BTN_DOWN] = 1'b0;
      end
      if (pressed[BTN_LEFT] && pressed[BTN_RIGHT]) begin
         pressed[BTN_LEFT]  = 1'b0;
         pressed[BTN_RIGHT] = 1'b0;
      end
      return pressed;
   endfunction

endpackage
`default_nettype wire

// File: rtl/gamepad_reader_if.sv
`default_nettype none
// gamepad_reader_if: pad wires plus the decoded button outputs of the reader.
// Rev 1.0
interface gamepad_reader_if;
   logic frame_tick;
   logic pad_data;
   logic pad_latch;
   logic pad_clk;
   logic A;
   logic B;
   logic select;
   logic start;
   logic up;
   logic down;
   logic left;
   logic right;
   logic a_press;
   logic valid;
   logic pad_present;

   modport reader (
      input  frame_tick, pad_data,
      output pad_latch, pad_clk, A, B, select, start, up, down, left, right,
             a_press, valid, pad_present
   );

   modport host (
      output frame_tick, pad_data,
      input  pad_latch, pad_clk, A, B, select, start, up, down, left, right,
             a_press, valid, pad_present
   );
endinterface
`default_nettype wire

// File: rtl/gamepad_reader_sync2.sv
`default_nettype none
// sync2: two-flop synchroniser for a single asynchronous input.
// Rev 1.0
module sync2 (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic d,
   output logic      q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule
`default_nettype wire

// File: rtl/gamepad_reader.sv
`default_nettype none
// gamepad_reader: on frame_tick, latches and shifts 8 bits out of an NES-style pad.
// Rev 1.0
module gamepad_reader
   import gamepad_reader_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   gamepad_reader_if.reader pad
);
   localparam logic [8:0] LATCH_LOAD = 9'(2 * CLK_DIV - 1);
   localparam logic [8:0] HALF_LOAD  = 9'(CLK_DIV - 1);

   state_t             state;
   state_t             state_next;
   logic [8:0]         div_cnt;
   logic [2:0]         bit_cnt;
   logic [NUM_BTN-1:0] shreg;
   logic [NUM_BTN-1:0] btn_q;
   logic [NUM_BTN-1:0] btn_next;
   logic               data_sync;
   logic               div_last;
   logic               sample;
   logic               latch_q;
   logic               pclk_q;
   logic               valid_q;
   logic               a_press_q;
   logic               present_q;

   sync2 u_sync2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pad.pad_data),
      .q     (data_sync)
   );

   assign div_last = (div_cnt == 9'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      sample     = 1'b0;
      btn_next   = decode_buttons(shreg);
      case (state)
         IDLE: begin
            if (pad.frame_tick) begin
               state_next = LATCH;
            end
         end
         LATCH: begin
            if (div_last) begin
               sample     = 1'b1;
               state_next = PULSE_HI;
            end
         end
         PULSE_HI: begin
            if (div_last) begin
               state_next = PULSE_LO;
            end
         end
         PULSE_LO: begin
            if (div_last) begin
               sample     = 1'b1;
               state_next = (bit_cnt == 3'd7) ? DONE : PULSE_HI;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Every transition reloads the divider, so the count always times the new state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         div_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         btn_q     <= '0;
         latch_q   <= 1'b0;
         pclk_q    <= 1'b0;
         valid_q   <= 1'b0;
         a_press_q <= 1'b0;
         present_q <= 1'b0;
      end else begin
         if (state_next != state) begin
            div_cnt <= (state_next == LATCH) ? LATCH_LOAD : HALF_LOAD;
         end else if (!div_last) begin
            div_cnt <= div_cnt - 9'd1;
         end

         if (state == IDLE) begin
            bit_cnt <= '0;
         end else if (sample) begin
            shreg[bit_cnt] <= data_sync;
            bit_cnt        <= bit_cnt + 3'd1;
         end

         latch_q   <= (state_next == LATCH);
         pclk_q    <= (state_next == PULSE_HI);
         valid_q   <= (state == DONE);
         a_press_q <= (state == DONE) && btn_next[BTN_A] && !btn_q[BTN_A];

         if (state == DONE) begin
            btn_q     <= btn_next;
            present_q <= (shreg != '0);
         end
      end
   end

   assign pad.pad_latch   = latch_q;
   assign pad.pad_clk     = pclk_q;
   assign pad.valid       = valid_q;
   assign pad.a_press     = a_press_q;
   assign pad.pad_present = present_q;
   assign pad.A           = btn_q[BTN_A];
   assign pad.B           = btn_q[BTN_B];
   assign pad.select      = btn_q[BTN_SELECT];
   assign pad.start       = btn_q[BTN_START];
   assign pad.up          = btn_q[BTN_UP];
   assign pad.down        = btn_q[BTN_DOWN];
   assign pad.left        = btn_q[BTN_LEFT];
   assign pad.right       = btn_q[BTN_RIGHT];

endmodule
`default_nettype wire

// File: tb/tb_gamepad_reader.sv
`default_nettype none
// tb_gamepad_reader: pad model, per-cycle behavioural reference and directed/random polls.
// Rev 1.0
module tb_gamepad_reader;
   localparam int D = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] raw   = 8'hFF;
   logic [3:0] idx   = 4'd0;
   logic       pclk_prev = 1'b0;
   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 0;

   gamepad_reader_if pif ();

   gamepad_reader #(.CLK_DIV(D)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (pif)
   );

   always #5 clk = ~clk;

   // Pad: shift register reloaded while latch is high, advanced on each pad_clk rise.
   assign pif.pad_data = (idx < 4'd8) ? raw[idx[2:0]] : 1'b0;
   always @(posedge clk) begin
      if (pif.pad_latch === 1'b1) begin
         idx <= 4'd0;
      end else if (pif.pad_clk === 1'b1 && !pclk_prev && idx < 4'd8) begin
         idx <= idx + 4'd1;
      end
      pclk_prev <= (pif.pad_clk === 1'b1);
   end

   // Reference: a poll is a fixed timeline measured from the edge that accepts frame_tick.
   bit         busy = 0;
   int         ecount = 0;
   int         start_e = 0;
   logic [7:0] m_btn = 8'h00;
   logic       m_latch = 0, m_pclk = 0, m_valid = 0, m_apress = 0, m_present = 0;

   function automatic logic [7:0] expect_buttons(input logic [7:0] r);
      logic [7:0] p;
      p = ~r;
      if (r == 8'h00) return 8'h00;
      if (p[4] && p[5]) p[5:4] = 2'b00;
      if (p[6] && p[7]) p[7:6] = 2'b00;
      return p;
   endfunction

   initial forever begin
      int         r;
      logic [7:0] nb;
      @(posedge clk);
      ecount++;
      m_valid = 0; m_apress = 0; m_latch = 0; m_pclk = 0;
      if (!rst_n) begin
         busy = 0; m_btn = 8'h00; m_present = 0;
      end else begin
         if (busy && (ecount - start_e) >= 16 * D + 2) busy = 0;
         if (!busy && pif.frame_tick === 1'b1) begin
            busy = 1; start_e = ecount;
         end
         if (busy) begin
            r = ecount - start_e;
            m_latch = (r < 2 * D);
            m_pclk  = (r >= 2 * D) && (r < 16 * D) && (((r - 2 * D) % (2 * D)) < D);
            if (r == 16 * D + 1) begin
               nb        = expect_buttons(raw);
               m_apress  = nb[0] && !m_btn[0];
               m_btn     = nb;
               m_present = (raw != 8'h00);
               m_valid   = 1;
            end
         end
      end
   end

   function automatic logic [9:0] btn_vec();
      return {pif.a_press, pif.pad_present, pif.right, pif.left, pif.down, pif.up,
              pif.start, pif.select, pif.B, pif.A};
   endfunction

   initial forever begin
      logic [12:0] act, exp;
      @(negedge clk);
      if (chk_en) begin
         act = {pif.pad_latch, pif.pad_clk, pif.valid, btn_vec()};
         exp = {m_latch, m_pclk, m_valid, m_apress, m_present, m_btn};
         checks++;
         if (act !== exp) begin
            errors++;
            $display("FAIL outputs edge %0d: got %b expected %b", ecount, act, exp);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic poll(input logic [7:0] r, output int lat);
      raw = r;
      pif.frame_tick = 1'b1;
      lat = -1;
      for (int i = 0; i <= 200; i++) begin
         @(negedge clk);
         pif.frame_tick = 1'b0;
         if (pif.valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   initial begin
      int lat, nvalid, vlat, nlatch, npulse;
      logic prev_pclk;
      pif.frame_tick = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("reset_outputs", {19'd0, pif.pad_latch, pif.pad_clk, pif.valid, btn_vec()}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      poll(8'b1111_1110, lat);
      check("a_only_latency", lat, 65);
      check("a_only_buttons", btn_vec(), 10'b11_0000_0001);
      poll(8'b1111_1110, lat);
      check("a_repeat_latency", lat, 65);
      check("a_repeat_buttons", btn_vec(), 10'b01_0000_0001);
      poll(8'hFF, lat);
      check("none_pressed", btn_vec(), 10'b01_0000_0000);
      poll(8'b1100_1111, lat);
      check("up_down_conflict", btn_vec(), 10'b01_0000_0000);
      poll(8'b0011_1111, lat);
      check("left_right_conflict", btn_vec(), 10'b01_0000_0000);
      poll(8'h00, lat);
      check("no_pad", btn_vec(), 10'b00_0000_0000);
      poll(8'b1110_1101, lat);
      check("b_up_buttons", btn_vec(), 10'b01_0001_0010);

      nvalid = 0; vlat = -1; nlatch = 0; npulse = 0; prev_pclk = 1'b0;
      pif.frame_tick = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         @(negedge clk);
         if (pif.valid === 1'b1) begin
            nvalid++;
            vlat = i;
         end
         if (pif.pad_latch === 1'b1) nlatch++;
         if (pif.pad_clk === 1'b1 && !prev_pclk) npulse++;
         prev_pclk = (pif.pad_clk === 1'b1);
         pif.frame_tick = (i == 9);
      end
      check("double_tick_valid_count", nvalid, 1);
      check("double_tick_latency", vlat, 65);
      check("latch_cycles", nlatch, 8);
      check("pad_clk_pulses", npulse, 7);

      nvalid = 0;
      raw = 8'hFE;
      pif.frame_tick = 1'b1;
      for (int i = 0; i <= 130; i++) begin
         @(negedge clk);
         pif.frame_tick = 1'b0;
         if (pif.valid === 1'b1) nvalid++;
         if (i == 29) rst_n = 1'b0;
         if (i == 30) begin
            check("abort_latch_clk", {pif.pad_latch, pif.pad_clk}, 2'b00);
            rst_n = 1'b1;
         end
      end
      check("abort_no_valid", nvalid, 0);
      check("abort_outputs_zero", btn_vec(), 10'd0);

      for (int p = 0; p < 40; p++) begin
         bit aborted;
         int extra;
         aborted = 0;
         extra = $urandom_range(0, 12);
         case ($urandom_range(0, 5))
            0: raw = 8'h00;
            1: raw = 8'hFF;
            2: raw = 8'hCF;
            3: raw = 8'h3F;
            default: raw = 8'($urandom);
         endcase
         pif.frame_tick = 1'b1;
         for (int i = 0; i < 70 + extra; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            pif.frame_tick = 1'b0;
            if (!aborted && i < 60) begin
               if ($urandom_range(0, 7) == 0) pif.frame_tick = 1'b1;
               if ($urandom_range(0, 49) == 0) begin
                  rst_n = 1'b0;
                  aborted = 1;
               end
            end
         end
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
